// File: rtl/rn_release_sequencer.sv
// Reset-release sequencer for the active-low RN pins of async-clear flop banks.
// Holds every domain in reset, then releases them in order with a programmable stagger.
module rn_release_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 2,
  parameter int NUM_DOMAINS = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   REQ,
  output logic [NUM_DOMAINS-1:0] RN,
  output logic                   READY,
  output logic                   CAUSE
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_RELEASE = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_badHold
    $error("HOLD_CYCLES must be in 1..255");
  end
  if (STAGGER < 1 || STAGGER > 255) begin : g_badStagger
    $error("STAGGER must be in 1..255");
  end
  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8) begin : g_badDomains
    $error("NUM_DOMAINS must be in 1..8");
  end

  logic [1:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic [NUM_DOMAINS-1:0] r_rn;
  logic                   r_ready;
  logic                   r_cause;

  logic [CW-1:0] w_cntInc;
  logic          w_holdDone;
  logic          w_stagDone;
  logic          w_lastIdx;

  assign w_cntInc   = r_cnt + CW'(1);
  assign w_holdDone = (w_cntInc == CW'(HOLD_CYCLES));
  assign w_stagDone = (w_cntInc == CW'(STAGGER));
  assign w_lastIdx  = (r_idx == IW'(NUM_DOMAINS - 1));

  // Counters stop one short of their terminal value, so cnt never wraps.
  always_ff @(posedge CLK) begin
    if (RST || REQ) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rn    <= '0;
      r_ready <= 1'b0;
      r_cause <= ~RST;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (w_holdDone) begin
            r_rn[0] <= 1'b1;
            r_cnt   <= '0;
            if (NUM_DOMAINS == 1) begin
              r_state <= S_RUN;
              r_ready <= 1'b1;
            end else begin
              r_state <= S_RELEASE;
              r_idx   <= IW'(1);
            end
          end else begin
            r_cnt <= w_cntInc;
          end
        end
        S_RELEASE: begin
          if (w_stagDone) begin
            r_rn[r_idx] <= 1'b1;
            r_cnt       <= '0;
            if (w_lastIdx) begin
              r_state <= S_RUN;
              r_ready <= 1'b1;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else begin
            r_cnt <= w_cntInc;
          end
        end
        S_RUN: begin
          r_state <= S_RUN;
        end
        default: begin
          r_state <= S_HOLD;
          r_cnt   <= '0;
          r_idx   <= '0;
          r_rn    <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign RN    = r_rn;
  assign READY = r_ready;
  assign CAUSE = r_cause;

endmodule

// File: tb/tb_rn_release_sequencer.sv
// Bench for rn_release_sequencer: default 16/2/4 instance plus a 1/1/1 instance on shared inputs,
// compared each cycle against a qualifying-edge-count model, with literal checkpoints.
module tb_rn_release_sequencer;

  localparam int HOLD0 = 16, STAG0 = 2, ND0 = 4;
  localparam int HOLD1 = 1,  STAG1 = 1, ND1 = 1;

  logic           clk;
  logic           rst;
  logic           req;
  logic [ND0-1:0] rn0;
  logic           ready0;
  logic           cause0;
  logic [ND1-1:0] rn1;
  logic           ready1;
  logic           cause1;

  int checks = 0;
  int errors = 0;

  // Model state: qualifying edges since the last reset/request, and sticky cause.
  int   qEdges = 0;
  logic modelCause = 1'b0;
  bit   modelValid = 1'b0;

  rn_release_sequencer #(.HOLD_CYCLES(HOLD0), .STAGGER(STAG0), .NUM_DOMAINS(ND0)) dut0 (
    .CLK(clk), .RST(rst), .REQ(req), .RN(rn0), .READY(ready0), .CAUSE(cause0)
  );

  rn_release_sequencer #(.HOLD_CYCLES(HOLD1), .STAGGER(STAG1), .NUM_DOMAINS(ND1)) dut1 (
    .CLK(clk), .RST(rst), .REQ(req), .RN(rn1), .READY(ready1), .CAUSE(cause1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Domain i is released once hold + i*stagger qualifying edges have passed.
  function automatic logic [7:0] expRn(int q, int hold, int stag, int nd);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < nd; i++) v[i] = (q >= hold + i * stag);
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst || req) begin
      qEdges     = 0;
      modelCause = rst ? 1'b0 : 1'b1;
      modelValid = 1'b1;
    end else if (qEdges < 100000) begin
      qEdges = qEdges + 1;
    end
  end

  task automatic compare(string name, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model, plus structural properties.
  always @(negedge clk) begin
    if (modelValid) begin
      logic [7:0] e0;
      logic [7:0] e1;
      e0 = expRn(qEdges, HOLD0, STAG0, ND0);
      e1 = expRn(qEdges, HOLD1, STAG1, ND1);
      compare("rn0", 8'(rn0), e0);
      compare("ready0", 8'(ready0), 8'(qEdges >= HOLD0 + (ND0 - 1) * STAG0));
      compare("cause0", 8'(cause0), 8'(modelCause));
      compare("rn1", 8'(rn1), e1);
      compare("ready1", 8'(ready1), 8'(qEdges >= HOLD1 + (ND1 - 1) * STAG1));
      compare("cause1", 8'(cause1), 8'(modelCause));
      compare("thermo0", 8'(((rn0 + ND0'(1)) & rn0) == '0), 8'd1);
      compare("readyAnd0", 8'(ready0), 8'(&rn0));
    end
  end

  task automatic applyStimulus(input logic r, input logic q, input int n);
    repeat (n) begin
      rst = r;
      req = q;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(string name, logic [ND0-1:0] eRn, logic eReady, logic eCause);
    compare({name, ".rn"}, 8'(rn0), 8'(eRn));
    compare({name, ".ready"}, 8'(ready0), 8'(eReady));
    compare({name, ".cause"}, 8'(cause0), 8'(eCause));
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;

    // Power-on reset and first release sequence.
    applyStimulus(1, 0, 3);
    checkOutput("reset", 4'b0000, 0, 0);
    compare("small.reset", 8'({rn1, ready1}), 8'b00);
    applyStimulus(0, 0, 1);
    compare("small.e1", 8'({rn1, ready1}), 8'b11);
    applyStimulus(0, 0, 14);
    checkOutput("e15", 4'b0000, 0, 0);
    applyStimulus(0, 0, 1);
    checkOutput("e16", 4'b0001, 0, 0);
    applyStimulus(0, 0, 2);
    checkOutput("e18", 4'b0011, 0, 0);
    applyStimulus(0, 0, 2);
    checkOutput("e20", 4'b0111, 0, 0);
    applyStimulus(0, 0, 2);
    checkOutput("e22", 4'b1111, 1, 0);
    applyStimulus(0, 0, 5);

    // Soft request from RUN, then full re-release.
    applyStimulus(0, 1, 1);
    checkOutput("reqPulse", 4'b0000, 0, 1);
    applyStimulus(0, 0, 16);
    checkOutput("req.e16", 4'b0001, 0, 1);
    applyStimulus(0, 0, 6);
    checkOutput("req.e22", 4'b1111, 1, 1);

    // Abort in the middle of the stagger phase.
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 19);
    checkOutput("abort.e19", 4'b0011, 0, 1);
    applyStimulus(0, 1, 1);
    checkOutput("abort.pulse", 4'b0000, 0, 1);
    applyStimulus(0, 0, 15);
    checkOutput("abort.e15", 4'b0000, 0, 1);
    applyStimulus(0, 0, 1);
    checkOutput("abort.e16", 4'b0001, 0, 1);

    // RST wins over REQ, then a held request keeps everything in reset.
    applyStimulus(1, 1, 1);
    checkOutput("both", 4'b0000, 0, 0);
    applyStimulus(0, 1, 10);
    checkOutput("reqHeld", 4'b0000, 0, 1);
    applyStimulus(0, 0, 15);
    checkOutput("reqHeld.e15", 4'b0000, 0, 1);
    applyStimulus(0, 0, 1);
    checkOutput("reqHeld.e16", 4'b0001, 0, 1);
    applyStimulus(0, 0, 8);

    // Randomised resets and requests with occasional long quiet stretches.
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4)       applyStimulus(1, $urandom_range(0, 1), 1);
      else if (r < 10) applyStimulus(0, 1, $urandom_range(1, 3));
      else if (r < 20) applyStimulus(0, 0, $urandom_range(15, 30));
      else             applyStimulus(0, 0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
